tx_point_test_rx_multilane: RTL and testbench

- Receiver-side responder for the TX-initiated point test (D2C) sideband handshake, generalised to NUM_LANES data lanes.
- Adds a handshake timeout, result masking for unused lanes, and an aggregate pass flag.
- Sits between the sideband message decoder/encoder and the mainband/valtrain pattern comparators, with the TX-side point-test block sharing the sideband request path.

---
 rtl/point_test_pkg.sv | 27 ++
 rtl/sb_send_handshake.sv | 14 +
 rtl/tx_point_test_rx_multilane.sv | 99 +++++++++
 tb/tb_tx_point_test_rx_multilane.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/point_test_pkg.sv
// point_test_pkg: sideband codes, comparator control encodings and states shared by the point-test blocks
package point_test_pkg;
  localparam logic [3:0] TEST_REQ    = 4'b0001;
  localparam logic [3:0] TEST_RESP   = 4'b0010;
  localparam logic [3:0] CLR_REQ     = 4'b0011;
  localparam logic [3:0] CLR_RESP    = 4'b0100;
  localparam logic [3:0] RESULT_REQ  = 4'b0101;
  localparam logic [3:0] RESULT_RESP = 4'b0110;
  localparam logic [3:0] END_REQ     = 4'b0111;
  localparam logic [3:0] END_RESP    = 4'b1000;
  localparam logic [1:0] CW_IDLE    = 2'b00;
  localparam logic [1:0] CW_CLEAR   = 2'b01;
  localparam logic [1:0] CW_LFSR    = 2'b10;
  localparam logic [1:0] CW_PERLANE = 2'b11;
  typedef enum logic [3:0] {
    IDLE, WAIT_TEST_REQ, SEND_TEST_RESP, WAIT_CLR_REQ, SEND_CLR_RESP, WAIT_RESULT_REQ,
    SEND_RESULT_RESP, WAIT_END_REQ, SEND_END_RESP, DONE, TIMEOUT
  } state_t;
  function automatic logic [3:0] req_of(input state_t s);
    return s == WAIT_TEST_REQ ? TEST_REQ : s == WAIT_CLR_REQ ? CLR_REQ :
           s == WAIT_RESULT_REQ ? RESULT_REQ : END_REQ;
  endfunction
  function automatic logic [3:0] resp_of(input state_t s);
    return s == SEND_TEST_RESP ? TEST_RESP : s == SEND_CLR_RESP ? CLR_RESP :
           s == SEND_RESULT_RESP ? RESULT_RESP : END_RESP;
  endfunction
endpackage

// File: rtl/sb_send_handshake.sv
// sb_send_handshake: sideband send request, deferred while the TX side owns the path, completed by busy negedge
module sb_send_handshake (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic i_valid_tx,
  input  logic i_busy_negedge_detected,
  output logic o_valid,
  output logic o_done
);
  assign o_done = o_valid && i_busy_negedge_detected;
  always_ff @(posedge clk)
    o_valid <= (rst || !active) ? 1'b0 : o_valid ? !i_busy_negedge_detected : !i_valid_tx;
endmodule

// File: rtl/tx_point_test_rx_multilane.sv
// tx_point_test_rx_multilane: RX responder for the TX-initiated multilane point test with timeout and lane masking
module tx_point_test_rx_multilane
  import point_test_pkg::*;
#(
  parameter int NUM_LANES   = 16,
  parameter int MSG_W       = 4,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 800000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_mainband_or_valtrain_test,
  input  logic                 i_lfsr_or_perlane,
  input  logic [NUM_LANES-1:0] i_lane_mask,
  input  logic                 i_valid_tx,
  input  logic                 i_busy_negedge_detected,
  input  logic [MSG_W-1:0]     i_sideband_message,
  input  logic                 i_sideband_message_valid,
  input  logic [NUM_LANES-1:0] i_comparison_results,
  input  logic                 i_valid_result,
  output logic [MSG_W-1:0]     o_sideband_message,
  output logic [15:0]          o_sideband_data,
  output logic                 o_msg_info,
  output logic                 o_valid_rx,
  output logic                 o_data_valid,
  output logic [1:0]           o_mainband_pattern_compartor_cw,
  output logic                 o_comparison_valid_en,
  output logic                 o_all_pass,
  output logic                 o_timeout,
  output logic                 o_test_ack_rx
);
  state_t state, nxt, succ;
  logic [TIMEOUT_W-1:0] cnt;
  logic [NUM_LANES-1:0] res, res_q;
  logic in_wait, in_send, hit, tc, done;
  assign in_wait = state inside {WAIT_TEST_REQ, WAIT_CLR_REQ, WAIT_RESULT_REQ, WAIT_END_REQ};
  assign in_send = state inside {SEND_TEST_RESP, SEND_CLR_RESP, SEND_RESULT_RESP, SEND_END_RESP};
  assign hit = in_wait && i_sideband_message_valid && i_sideband_message == MSG_W'(req_of(state));
  assign tc = cnt == TIMEOUT_W'(TIMEOUT_CYC - 1);
  assign succ = state_t'(state + 4'd1);
  assign res = i_comparison_results | ~i_lane_mask;
  assign o_sideband_data = 16'(res_q);
  assign o_data_valid = o_valid_rx && state == SEND_RESULT_RESP;
  always_comb
    nxt = state == IDLE ? WAIT_TEST_REQ : in_wait ? (hit ? succ : tc ? TIMEOUT : state) :
          (in_send && done) ? succ : state;
  sb_send_handshake u_hs (
    .clk                     (clk),
    .rst                     (rst),
    .active                  (i_en && in_send),
    .i_valid_tx              (i_valid_tx),
    .i_busy_negedge_detected (i_busy_negedge_detected),
    .o_valid                 (o_valid_rx),
    .o_done                  (done)
  );
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      state <= IDLE;
      cnt <= '0;
      o_sideband_message <= '0;
      res_q <= '0;
      o_msg_info <= 1'b0;
      o_mainband_pattern_compartor_cw <= CW_IDLE;
      o_comparison_valid_en <= 1'b0;
      o_all_pass <= 1'b0;
      o_test_ack_rx <= 1'b0;
      if (rst) o_timeout <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || !in_wait) ? '0 : cnt + 1'b1;
      if (o_mainband_pattern_compartor_cw == CW_CLEAR) o_mainband_pattern_compartor_cw <= CW_IDLE;
      if (nxt != state) begin
        if (nxt == WAIT_TEST_REQ) o_timeout <= 1'b0;
        if (nxt inside {SEND_TEST_RESP, SEND_CLR_RESP, SEND_RESULT_RESP, SEND_END_RESP})
          o_sideband_message <= MSG_W'(resp_of(nxt));
        if (nxt == SEND_CLR_RESP && !i_mainband_or_valtrain_test)
          o_mainband_pattern_compartor_cw <= CW_CLEAR;
        if (state == SEND_CLR_RESP) begin
          if (i_mainband_or_valtrain_test) o_comparison_valid_en <= 1'b1;
          else o_mainband_pattern_compartor_cw <= i_lfsr_or_perlane ? CW_PERLANE : CW_LFSR;
        end
        if (nxt == SEND_RESULT_RESP) begin
          o_mainband_pattern_compartor_cw <= CW_IDLE;
          o_comparison_valid_en <= 1'b0;
          res_q <= res;
          o_msg_info <= i_valid_result;
          o_all_pass <= &res;
        end
        if (nxt == DONE) o_test_ack_rx <= 1'b1;
        if (nxt == TIMEOUT) begin
          o_timeout <= 1'b1;
          o_test_ack_rx <= 1'b1;
          o_mainband_pattern_compartor_cw <= CW_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_tx_point_test_rx_multilane.sv
// tb_tx_point_test_rx_multilane: directed and randomized point-test flows checked against a rule-level model
module tb_tx_point_test_rx_multilane;
  localparam int NL = 12;
  localparam int TO = 100;
  logic clk = 0, rst = 1, i_en = 0, vt = 0, pl = 0, i_valid_tx = 0, busy = 0, msg_v = 0, vres = 0;
  logic [NL-1:0] mask = '0, cres = '0;
  logic [3:0] msg = '0;
  logic [3:0] o_msg;
  logic [15:0] o_data;
  logic o_msg_info, o_valid_rx, o_data_valid, o_cve, o_all_pass, o_timeout, o_ack;
  logic [1:0] o_cw;
  int vectors = 0, miscompares = 0;
  tx_point_test_rx_multilane #(.NUM_LANES(NL), .TIMEOUT_CYC(TO)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .i_en                            (i_en),
    .i_mainband_or_valtrain_test     (vt),
    .i_lfsr_or_perlane               (pl),
    .i_lane_mask                     (mask),
    .i_valid_tx                      (i_valid_tx),
    .i_busy_negedge_detected         (busy),
    .i_sideband_message              (msg),
    .i_sideband_message_valid        (msg_v),
    .i_comparison_results            (cres),
    .i_valid_result                  (vres),
    .o_sideband_message              (o_msg),
    .o_sideband_data                 (o_data),
    .o_msg_info                      (o_msg_info),
    .o_valid_rx                      (o_valid_rx),
    .o_data_valid                    (o_data_valid),
    .o_mainband_pattern_compartor_cw (o_cw),
    .o_comparison_valid_en           (o_cve),
    .o_all_pass                      (o_all_pass),
    .o_timeout                       (o_timeout),
    .o_test_ack_rx                   (o_ack)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_req(input logic [3:0] code);
    msg = code;
    msg_v = 1;
    step();
    msg_v = 0;
  endtask
  task automatic rise(input int hold);
    for (int i = 0; i < hold; i++) begin
      busy = (i == hold / 2);
      step();
      busy = 0;
      chk("deferred", o_valid_rx, 0);
    end
    i_valid_tx = 0;
    step();
    chk("valid_rise", o_valid_rx, 1);
  endtask
  task automatic finish_send();
    busy = 1;
    step();
    busy = 0;
    chk("valid_clear", o_valid_rx, 0);
  endtask
  task automatic flow(input logic f_vt, input logic f_pl, input int hold,
                      input logic [NL-1:0] f_mask, input logic [NL-1:0] f_res);
    logic [15:0] e;
    logic all, f_vres;
    logic [3:0] bad;
    e = '0;
    all = 1;
    for (int i = 0; i < NL; i++) begin
      e[i] = !f_mask[i] || f_res[i];
      all = all && e[i];
    end
    f_vres = 1'($urandom);
    vt = f_vt;
    pl = f_pl;
    i_en = 1;
    step();
    chk("start_timeout", o_timeout, 0);
    chk("start_ack", o_ack, 0);
    i_valid_tx = (hold > 0);
    send_req(4'h1);
    chk("test_resp", o_msg, 4'h2);
    chk("test_entry_valid", o_valid_rx, 0);
    rise(hold);
    finish_send();
    send_req(4'h3);
    chk("clr_resp", o_msg, 4'h4);
    chk("cw_clear", o_cw, f_vt ? 0 : 1);
    rise(0);
    chk("cw_after_clear", o_cw, 0);
    finish_send();
    chk("cw_run", o_cw, f_vt ? 0 : (f_pl ? 3 : 2));
    chk("cve_run", o_cve, f_vt);
    bad = 4'($urandom_range(0, 15));
    if (bad == 4'h5) bad = 4'h7;
    send_req(bad);
    step();
    chk("ignored_code", {o_valid_rx, o_msg}, {1'b0, 4'h4});
    mask = f_mask;
    cres = f_res;
    vres = f_vres;
    send_req(4'h5);
    chk("result_resp", o_msg, 4'h6);
    chk("result_cw", {o_cw, o_cve}, 0);
    chk("result_data", o_data, e);
    chk("result_info", o_msg_info, f_vres);
    chk("all_pass", o_all_pass, all);
    rise(0);
    chk("data_valid", o_data_valid, 1);
    send_req(4'h7);
    chk("send_ignores_msg", {o_msg, o_valid_rx}, {4'h6, 1'b1});
    finish_send();
    chk("data_valid_clear", o_data_valid, 0);
    cres = NL'($urandom);
    vres = ~vres;
    mask = NL'($urandom);
    send_req(4'h7);
    chk("end_resp", o_msg, 4'h8);
    rise(0);
    chk("end_no_data", o_data_valid, 0);
    finish_send();
    chk("done_ack", o_ack, 1);
    repeat (3) step();
    chk("done_hold", {o_ack, o_all_pass, o_msg_info, o_data}, {1'b1, all, f_vres, e});
    i_en = 0;
    step();
    chk("idle_clear", {o_msg, o_data, o_msg_info, o_valid_rx, o_data_valid, o_cw, o_cve, o_all_pass, o_ack, o_timeout}, 0);
  endtask
  initial begin
    step();
    step();
    chk("reset", {o_msg, o_data, o_msg_info, o_valid_rx, o_data_valid, o_cw, o_cve, o_all_pass, o_ack, o_timeout}, 0);
    rst = 0;
    step();
    flow(0, 0, 0, '1, '1);
    flow(0, 1, 0, NL'(12'h00F), NL'(12'h005));
    flow(0, 0, 20, NL'($urandom), NL'($urandom));
    flow(1, 0, 0, NL'($urandom), NL'($urandom));
    i_en = 1;
    step();
    send_req(4'h1);
    rise(0);
    finish_send();
    repeat (TO - 1) step();
    chk("pre_timeout", o_timeout, 0);
    step();
    chk("timeout", {o_timeout, o_ack, o_valid_rx, o_cw}, {1'b1, 1'b1, 1'b0, 2'b00});
    repeat (5) step();
    chk("timeout_hold", {o_timeout, o_ack}, 2'b11);
    i_en = 0;
    step();
    chk("timeout_sticky", {o_timeout, o_ack}, 2'b10);
    i_en = 1;
    step();
    chk("timeout_cleared", o_timeout, 0);
    send_req(4'h1);
    rise(0);
    finish_send();
    repeat (TO - 1) step();
    send_req(4'h3);
    chk("req_wins", {o_msg, o_timeout}, {4'h4, 1'b0});
    rise(0);
    i_en = 0;
    step();
    chk("abort", {o_valid_rx, o_cw, o_msg, o_ack}, 0);
    busy = 1;
    step();
    busy = 0;
    repeat (3) step();
    chk("abort_quiet", {o_valid_rx, o_msg}, 0);
    for (int k = 0; k < 6; k++)
      flow(1'($urandom), 1'($urandom), $urandom_range(0, 1) ? $urandom_range(1, 6) : 0,
           NL'($urandom), $urandom_range(0, 2) == 0 ? '1 : NL'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
